// File: rtl/spin_countdown.sv
`default_nettype none
// ============================================================================
// Module   : spin_countdown
// Purpose  : Spin-down step counter. A load starts a spin of load_val steps.
//            Each qualifying tick moves the spin toward zero, and the spin
//            slows as it nears the end:
//              count >  SLOW_AT                : 1 decrement per tick
//              SLOWEST_AT < count <= SLOW_AT   : 1 decrement per 2 ticks
//              count <= SLOWEST_AT             : 1 decrement per 4 ticks
//            When the count reaches zero the block pulses done for one cycle
//            and then returns to idle.
// Ports    : clk      - clock; all state updates on the rising edge
//            clr      - asynchronous active-low reset
//            en       - global enable; tick and load are ignored when low
//            load     - start or restart a spin with load_val
//            load_val - spin length in steps (0-63)
//            tick     - step strobe, one clk cycle wide per event
//            count    - remaining steps (registered)
//            busy     - high while a spin is running
//            step     - one-cycle pulse in the cycle after each decrement
//            done     - one-cycle pulse when a spin completes
// Revision : 1.0 - initial release
// ============================================================================
module spin_countdown #(
    parameter int SLOW_AT    = 8,   // legal only if SLOWEST_AT < SLOW_AT < 63
    parameter int SLOWEST_AT = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       tick,
    output logic [5:0] count,
    output logic       busy,
    output logic       step,
    output logic       done
);

    // Thresholds narrowed to the count width so that comparisons stay
    // width-matched.
    localparam logic [5:0] c_SLOW_AT    = 6'(SLOW_AT);
    localparam logic [5:0] c_SLOWEST_AT = 6'(SLOWEST_AT);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_RUN  = 2'd1,
        c_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [5:0] r_count;
    logic [1:0] r_pre;
    logic       r_step;

    // Terminal prescaler value (divisor - 1). It is taken from the count
    // before the edge, so the tick that crosses a threshold still uses the
    // rate of the band it started in.
    logic [1:0] w_pre_max;

    always_comb begin
        w_pre_max = 2'd0;
        if (r_count <= c_SLOWEST_AT) begin
            w_pre_max = 2'd3;
        end else if (r_count <= c_SLOW_AT) begin
            w_pre_max = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= c_IDLE;
            r_count <= 6'd0;
            r_pre   <= 2'd0;
            r_step  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (en && load) begin
                        r_count <= load_val;
                        r_pre   <= 2'd0;
                        r_state <= (load_val != 6'd0) ? c_RUN : c_DONE;
                    end
                end

                c_RUN: begin
                    if (en) begin
                        if (load) begin
                            // A reload takes priority, and a tick in the
                            // same cycle is dropped.
                            r_count <= load_val;
                            r_pre   <= 2'd0;
                            r_state <= (load_val != 6'd0) ? c_RUN : c_DONE;
                        end else if (tick) begin
                            if (r_pre == w_pre_max) begin
                                r_pre <= 2'd0;
                                // RUN always holds a non-zero count. The guard
                                // keeps the counter from wrapping below zero.
                                if (r_count != 6'd0) begin
                                    r_count <= r_count - 6'd1;
                                    r_step  <= 1'b1;
                                end
                                if (r_count <= 6'd1) begin
                                    r_state <= c_DONE;
                                end
                            end else begin
                                r_pre <= r_pre + 2'd1;
                            end
                        end
                    end
                end

                c_DONE: begin
                    // DONE lasts exactly one cycle, whatever en, load or
                    // tick are doing.
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign count = r_count;
    assign step  = r_step;
    assign busy  = (r_state == c_RUN);
    assign done  = (r_state == c_DONE);

endmodule
`default_nettype wire
